// File: rtl/mtm_alu_deserializer.sv
//------------------------------------------------------------------------------
// mtm_alu_deserializer
//
// Receive side of the MTM ALU serial link. Samples `sin` once per clock and
// decodes 11-bit packets:
//
//   start(0) | flag(0=data, 1=ctl) | d7 d6 d5 d4 d3 d2 d1 d0 | stop(1)
//
// A command is N_DATA_PKT data packets (B3..B0 then A3..A0, most significant
// byte first) followed by one ctl packet {1'b0, OP[2:0], CRC[3:0]}. When the
// ctl packet's stop bit is sampled, the command is checked and exactly one
// result strobe is issued. Priority, highest first:
//   err_data  - wrong data-packet count, or ctl byte bit7 set
//   err_crc   - CRC4 over {B, A, 1'b1, OP} differs from the CRC field
//   err_op    - OP is not AND(000), OR(001), ADD(100) or SUB(101)
//   out_valid - A/B/OP are loaded and valid
// A stop bit of 0 on any packet is a framing error. It raises err_data,
// clears the packet count and leaves the assembled operand bytes unchanged.
//
// Configuration macro:
//   MTM_DESER_CRC_CHECK_EN  defined   : CRC4 is computed and checked.
//                           undefined : no CRC logic; err_crc is always 0,
//                                       and the CRC field is ignored.
//
// Parameters:
//   N_DATA_PKT  data packets required before the ctl packet (default 8)
//
// Ports:
//   clk        in   1   clock
//   rst_n      in   1   reset, synchronous, active-low
//   sin        in   1   serial input, idles high
//   A          out  32  operand A (last 4 data bytes), held until next out_valid
//   B          out  32  operand B (first 4 data bytes), held until next out_valid
//   OP         out  3   operation code, held until next out_valid
//   out_valid  out  1   1-clk strobe: A/B/OP valid, no error
//   err_data   out  1   1-clk strobe: framing error or bad data-packet count
//   err_crc    out  1   1-clk strobe: CRC mismatch
//   err_op     out  1   1-clk strobe: illegal OP
//------------------------------------------------------------------------------
module mtm_alu_deserializer #(
  parameter int N_DATA_PKT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [2:0]  OP,
  output logic        out_valid,
  output logic        err_data,
  output logic        err_crc,
  output logic        err_op
);

  //----------------------------------------------------------------------------
  // Types and constants
  //----------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE,   // waiting for a start bit (sin == 0)
    S_FLAG,   // sampling the data/ctl flag bit
    S_DATA,   // shifting in the 8 payload bits, MSB first
    S_STOP    // sampling the stop bit; the packet completes on this edge
  } state_e;

  // Packet counter saturates one above the required count, so any surplus
  // of data packets is still visible as "not equal to N_DATA_PKT".
  localparam int               CNT_W   = $clog2(N_DATA_PKT + 2);
  localparam logic [CNT_W-1:0] PKT_REQ = CNT_W'(N_DATA_PKT);
  localparam logic [CNT_W-1:0] PKT_SAT = CNT_W'(N_DATA_PKT + 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  //----------------------------------------------------------------------------
  // State
  //----------------------------------------------------------------------------
  state_e             state_q,     state_d;
  logic [2:0]         bit_cnt_q,   bit_cnt_d;
  logic               is_ctl_q,    is_ctl_d;
  logic [7:0]         byte_sr_q,   byte_sr_d;
  logic [63:0]        ba_sr_q,     ba_sr_d;    // {B, A} as assembled
  logic [CNT_W-1:0]   pkt_cnt_q,   pkt_cnt_d;
  logic [31:0]        a_q,         a_d;
  logic [31:0]        b_q,         b_d;
  logic [2:0]         op_q,        op_d;
  logic               out_valid_q, out_valid_d;
  logic               err_data_q,  err_data_d;
  logic               err_crc_q,   err_crc_d;
  logic               err_op_q,    err_op_d;

  //----------------------------------------------------------------------------
  // Ctl-byte decode (only meaningful while in S_STOP of a ctl packet)
  //----------------------------------------------------------------------------
  logic [2:0] ctl_op;
  logic       op_legal;
  logic       crc_bad;

  assign ctl_op   = byte_sr_q[6:4];
  assign op_legal = (ctl_op == OP_AND) || (ctl_op == OP_OR) ||
                    (ctl_op == OP_ADD) || (ctl_op == OP_SUB);

`ifdef MTM_DESER_CRC_CHECK_EN
  // CRC4, polynomial x^4 + x + 1, initial value 0, processed MSB first.
  // Fully unrolled: the whole 68-bit stream is already held in registers
  // when the ctl stop bit arrives, so the check costs no extra cycles.
  function automatic logic [3:0] crc4(input logic [67:0] stream);
    logic [3:0] crc;
    logic       fb;
    crc = 4'b0000;
    for (int i = 67; i >= 0; i--) begin
      fb  = crc[3] ^ stream[i];
      crc = {crc[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return crc;
  endfunction

  logic [3:0] crc_calc;

  assign crc_calc = crc4({ba_sr_q, 1'b1, ctl_op});
  assign crc_bad  = (crc_calc != byte_sr_q[3:0]);
`else
  assign crc_bad  = 1'b0;
`endif

  //----------------------------------------------------------------------------
  // Next-state and strobe logic
  //----------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch. Strobes default to 0, which
    // is what makes them one clock wide.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    is_ctl_d    = is_ctl_q;
    byte_sr_d   = byte_sr_q;
    ba_sr_d     = ba_sr_q;
    pkt_cnt_d   = pkt_cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    out_valid_d = 1'b0;
    err_data_d  = 1'b0;
    err_crc_d   = 1'b0;
    err_op_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!sin) begin
          state_d = S_FLAG;
        end
      end

      S_FLAG: begin
        is_ctl_d  = sin;
        bit_cnt_d = 3'd0;
        state_d   = S_DATA;
      end

      S_DATA: begin
        byte_sr_d = {byte_sr_q[6:0], sin};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        // The next start bit may arrive on the very next edge, so always
        // return to IDLE here rather than waiting for an idle-high gap.
        state_d = S_IDLE;

        if (!sin) begin
          // Framing error: drop this packet and the command in progress.
          // Assembled operand bytes are left unchanged.
          err_data_d = 1'b1;
          pkt_cnt_d  = '0;
        end else if (!is_ctl_q) begin
          ba_sr_d = {ba_sr_q[55:0], byte_sr_q};
          if (pkt_cnt_q != PKT_SAT) begin
            pkt_cnt_d = pkt_cnt_q + 1'b1;
          end
        end else begin
          pkt_cnt_d = '0;
          if ((pkt_cnt_q != PKT_REQ) || byte_sr_q[7]) begin
            err_data_d = 1'b1;
          end else if (crc_bad) begin
            err_crc_d = 1'b1;
          end else if (!op_legal) begin
            err_op_d = 1'b1;
          end else begin
            out_valid_d = 1'b1;
            b_d         = ba_sr_q[63:32];
            a_d         = ba_sr_q[31:0];
            op_d        = ctl_op;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  //----------------------------------------------------------------------------
  // State registers
  //----------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: the reset is synchronous, so rst_n is only looked at on a clock
    // edge and does not appear in the sensitivity list. Every register,
    // including the operand shift register, is cleared so that a reset in
    // the middle of a packet abandons the whole command.
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      is_ctl_q    <= 1'b0;
      byte_sr_q   <= '0;
      ba_sr_q     <= '0;
      pkt_cnt_q   <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      out_valid_q <= 1'b0;
      err_data_q  <= 1'b0;
      err_crc_q   <= 1'b0;
      err_op_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register updates from the
      // values the comb block computed before this edge.
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      is_ctl_q    <= is_ctl_d;
      byte_sr_q   <= byte_sr_d;
      ba_sr_q     <= ba_sr_d;
      pkt_cnt_q   <= pkt_cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
      err_data_q  <= err_data_d;
      err_crc_q   <= err_crc_d;
      err_op_q    <= err_op_d;
    end
  end

  //----------------------------------------------------------------------------
  // Outputs
  //----------------------------------------------------------------------------
  assign A         = a_q;
  assign B         = b_q;
  assign OP        = op_q;
  assign out_valid = out_valid_q;
  assign err_data  = err_data_q;
  assign err_crc   = err_crc_q;
  assign err_op    = err_op_q;

  // The result strobes are mutually exclusive by construction.
  a_one_strobe: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({out_valid_q, err_data_q, err_crc_q, err_op_q}));

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
//------------------------------------------------------------------------------
// tb_mtm_alu_deserializer
//
// Self-checking bench for mtm_alu_deserializer. A frame-level reference model
// keeps the data bytes received so far in a queue and predicts each result
// strobe (kind, clock cycle, A/B/OP) from the packet rules. Predictions are
// compared against strobes captured from the DUT. Stimulus is a table of
// directed commands, several hand-written multi-cycle sequences and a
// randomized run.
//------------------------------------------------------------------------------
module tb_mtm_alu_deserializer;

  // Strobe vector encoding: {out_valid, err_data, err_crc, err_op}
  localparam logic [3:0] ST_NONE  = 4'b0000;
  localparam logic [3:0] ST_VALID = 4'b1000;
  localparam logic [3:0] ST_DATA  = 4'b0100;
  localparam logic [3:0] ST_CRC   = 4'b0010;
  localparam logic [3:0] ST_OP    = 4'b0001;

`ifdef MTM_DESER_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif
  // Expected strobe for a command whose only fault is its CRC field, and for
  // one with both a bad CRC and an illegal OP.
  localparam logic [3:0] ST_BADCRC       = CRC_EN ? ST_CRC : ST_VALID;
  localparam logic [3:0] ST_BADCRC_BADOP = CRC_EN ? ST_CRC : ST_OP;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        sin   = 1'b1;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  OP;
  logic        out_valid;
  logic        err_data;
  logic        err_crc;
  logic        err_op;

  mtm_alu_deserializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .A         (A),
    .B         (B),
    .OP        (OP),
    .out_valid (out_valid),
    .err_data  (err_data),
    .err_crc   (err_crc),
    .err_op    (err_op)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  //----------------------------------------------------------------------------
  // Strobe capture (sampled on the falling edge, away from the active edge)
  //----------------------------------------------------------------------------
  typedef struct {
    logic [3:0]  st;
    int unsigned cyc;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } ev_t;

  ev_t got_q[$];
  ev_t exp_q[$];

  always @(negedge clk) begin
    ev_t g;
    if ({out_valid, err_data, err_crc, err_op} != ST_NONE) begin
      g.st  = {out_valid, err_data, err_crc, err_op};
      g.cyc = cyc;
      g.a   = A;
      g.b   = B;
      g.op  = OP;
      got_q.push_back(g);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  //----------------------------------------------------------------------------
  // Reference model
  //----------------------------------------------------------------------------
  logic [7:0]  hist[$];     // most recent (up to 8) accepted data bytes
  int          run_cnt;     // data packets since the last ctl/framing error
  logic [31:0] exp_a;
  logic [31:0] exp_b;
  logic [2:0]  exp_op;

  // CRC as the remainder of polynomial long division: M(x)*x^4 mod x^4+x+1.
  function automatic logic [3:0] ref_crc(input logic [63:0] ab, input logic [2:0] op);
    logic [71:0] r;
    r = {ab, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--) begin
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    end
    return r[3:0];
  endfunction

  function automatic logic [63:0] last_ab();
    logic [63:0] ab;
    ab = '0;
    foreach (hist[i]) ab = {ab[55:0], hist[i]};
    return ab;
  endfunction

  task automatic model_reset();
    hist.delete();
    run_cnt = 0;
    exp_a   = '0;
    exp_b   = '0;
    exp_op  = '0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic model_pkt(input logic is_ctl, input logic [7:0] data,
                           input logic stop_ok, input int unsigned stop_cyc);
    ev_t         e;
    logic [63:0] ab;
    logic [2:0]  op;
    e.st  = ST_NONE;
    e.cyc = stop_cyc;
    if (!stop_ok) begin
      run_cnt = 0;
      e.st    = ST_DATA;
    end else if (!is_ctl) begin
      hist.push_back(data);
      if (hist.size() > 8) void'(hist.pop_front());
      run_cnt++;
    end else begin
      ab = last_ab();
      op = data[6:4];
      if (run_cnt != 8 || data[7])                        e.st = ST_DATA;
      else if (CRC_EN && ref_crc(ab, op) != data[3:0])    e.st = ST_CRC;
      else if (!(op inside {3'b000, 3'b001, 3'b100, 3'b101})) e.st = ST_OP;
      else begin
        e.st   = ST_VALID;
        exp_b  = ab[63:32];
        exp_a  = ab[31:0];
        exp_op = op;
      end
      run_cnt = 0;
    end
    if (e.st != ST_NONE) begin
      e.a  = exp_a;
      e.b  = exp_b;
      e.op = exp_op;
      exp_q.push_back(e);
    end
  endtask

  //----------------------------------------------------------------------------
  // Stimulus helpers
  //----------------------------------------------------------------------------
  task automatic send_bit(input logic b);
    @(negedge clk);
    sin = b;
  endtask

  task automatic send_pkt(input logic is_ctl, input logic [7:0] data, input logic stop_ok);
    send_bit(1'b0);
    send_bit(is_ctl);
    for (int i = 7; i >= 0; i--) send_bit(data[i]);
    send_bit(stop_ok);
    // The stop bit is sampled on the coming rising edge.
    model_pkt(is_ctl, data, stop_ok, cyc + 1);
  endtask

  // One command: n_data data packets then a ctl packet. bad_idx selects the
  // packet (n_data = the ctl packet) whose stop bit is forced to 0; -1 = none.
  task automatic send_frame(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                            input logic [3:0] crc_xor, input logic bit7,
                            input int n_data, input int bad_idx);
    logic [63:0] ab;
    logic [7:0]  d;
    ab = {b, a};
    for (int i = 0; i < n_data; i++) begin
      d = (i < 8) ? ab[63 - 8*i -: 8] : 8'hA5;
      send_pkt(1'b0, d, i != bad_idx);
    end
    send_pkt(1'b1, {bit7, op, ref_crc(ab, op) ^ crc_xor}, n_data != bad_idx);
  endtask

  // Idle a few clocks, then compare captured strobes with predictions.
  task automatic drain(output logic [3:0] last_st);
    ev_t g;
    ev_t e;
    last_st = ST_NONE;
    repeat (3) send_bit(1'b1);
    check("strobe_count", 64'(got_q.size()), 64'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      last_st = g.st;
      check("strobe_kind",  g.st,  e.st);
      check("strobe_cycle", g.cyc, e.cyc);
      check("strobe_B",     g.b,   e.b);
      check("strobe_A",     g.a,   e.a);
      check("strobe_OP",    g.op,  e.op);
    end
    got_q.delete();
    exp_q.delete();
    check("hold_B",  B,  exp_b);
    check("hold_A",  A,  exp_a);
    check("hold_OP", OP, exp_op);
  endtask

  //----------------------------------------------------------------------------
  // Directed command table
  //----------------------------------------------------------------------------
  typedef struct {
    logic [31:0] b;
    logic [31:0] a;
    logic [2:0]  op;
    logic [3:0]  crc_xor;
    logic        bit7;
    int          n_data;
    logic [3:0]  exp_st;
  } vec_t;

  vec_t vt[12];

  function automatic vec_t mk(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                              input logic [3:0] crc_xor, input logic bit7, input int n_data,
                              input logic [3:0] exp_st);
    vec_t v;
    v.b = b; v.a = a; v.op = op; v.crc_xor = crc_xor;
    v.bit7 = bit7; v.n_data = n_data; v.exp_st = exp_st;
    return v;
  endfunction

  //----------------------------------------------------------------------------
  // Test sequence
  //----------------------------------------------------------------------------
  initial begin
    logic [3:0]  st;
    logic [31:0] rb;
    logic [31:0] ra;
    logic [2:0]  rop;
    logic [3:0]  rx;
    logic        r7;
    int          rn;
    int          rbad;
    int          rsel;

    vt[0]  = mk(32'h0000_0003, 32'h0000_0002, 3'b100, 4'h0, 1'b0, 8, ST_VALID);
    vt[1]  = mk(32'hDEAD_BEEF, 32'h1234_5678, 3'b000, 4'h0, 1'b0, 7, ST_DATA);
    vt[2]  = mk(32'hDEAD_BEEF, 32'h1234_5678, 3'b000, 4'h0, 1'b0, 9, ST_DATA);
    vt[3]  = mk(32'hCAFE_F00D, 32'h0BAD_CAFE, 3'b101, 4'h1, 1'b0, 8, ST_BADCRC);
    vt[4]  = mk(32'h0000_0001, 32'h0000_0002, 3'b010, 4'h0, 1'b0, 8, ST_OP);
    vt[5]  = mk(32'h0000_0001, 32'h0000_0002, 3'b001, 4'h0, 1'b0, 8, ST_VALID);
    vt[6]  = mk(32'hFFFF_FFFF, 32'h0000_0000, 3'b100, 4'h0, 1'b1, 8, ST_DATA);
    vt[7]  = mk(32'h8000_0000, 32'h7FFF_FFFF, 3'b011, 4'h0, 1'b0, 8, ST_OP);
    vt[8]  = mk(32'h0000_0000, 32'h0000_0000, 3'b111, 4'h8, 1'b0, 8, ST_BADCRC_BADOP);
    vt[9]  = mk(32'h5555_5555, 32'hAAAA_AAAA, 3'b000, 4'hF, 1'b0, 7, ST_DATA);
    vt[10] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b101, 4'h0, 1'b0, 8, ST_VALID);
    vt[11] = mk(32'h0000_0000, 32'h0000_0000, 3'b110, 4'h0, 1'b0, 8, ST_OP);

    // 1) Reset held 20 clocks with the line idle.
    rst_n = 1'b0;
    sin   = 1'b1;
    model_reset();
    repeat (20) @(negedge clk);
    check("rst_A",       A,  32'h0);
    check("rst_B",       B,  32'h0);
    check("rst_OP",      OP, 3'h0);
    check("rst_strobes", {out_valid, err_data, err_crc, err_op}, ST_NONE);
    model_reset();
    rst_n = 1'b1;
    drain(st);

    // 2) B=3, A=2, ADD, correct CRC.
    send_frame(32'h3, 32'h2, 3'b100, 4'h0, 1'b0, 8, -1);
    drain(st);
    check("t2_strobe", st, ST_VALID);
    check("t2_B",  B,  32'h0000_0003);
    check("t2_A",  A,  32'h0000_0002);
    check("t2_OP", OP, 3'b100);

    // Directed table: counts, CRC, OP legality, bit7, priorities.
    foreach (vt[i]) begin
      send_frame(vt[i].b, vt[i].a, vt[i].op, vt[i].crc_xor, vt[i].bit7, vt[i].n_data, -1);
      drain(st);
      check($sformatf("vec%0d_strobe", i), st, vt[i].exp_st);
    end

    // 6a) Stop bit 0 in the 3rd data packet -> err_data on that packet.
    send_pkt(1'b0, 8'h11, 1'b1);
    send_pkt(1'b0, 8'h22, 1'b1);
    send_pkt(1'b0, 8'h33, 1'b0);
    drain(st);
    check("frame_err_data_pkt", st, ST_DATA);
    send_frame(32'h0102_0304, 32'h0506_0708, 3'b000, 4'h0, 1'b0, 8, -1);
    drain(st);
    check("after_frame_err_valid", st, ST_VALID);
    check("after_frame_err_A", A, 32'h0506_0708);

    // Framing error on the ctl packet: err_data, operands held.
    send_frame(32'h1111_2222, 32'h3333_4444, 3'b001, 4'h0, 1'b0, 8, 8);
    drain(st);
    check("frame_err_ctl_pkt", st, ST_DATA);
    check("frame_err_ctl_hold_B", B, 32'h0102_0304);

    // Back-to-back commands with no idle gap between stop and start bits.
    send_frame(32'hA0A0_A0A0, 32'h0B0B_0B0B, 3'b101, 4'h0, 1'b0, 8, -1);
    send_frame(32'hC0C0_C0C0, 32'h0D0D_0D0D, 3'b000, 4'h0, 1'b0, 8, -1);
    drain(st);
    check("b2b_last_strobe", st, ST_VALID);
    check("b2b_last_B", B, 32'hC0C0_C0C0);

    // 6b) Reset in the middle of the 5th data packet: no strobe.
    for (int i = 0; i < 4; i++) send_pkt(1'b0, 8'(8'h40 + i), 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    sin   = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_reset_no_strobe", 64'(got_q.size()), 64'd0);
    check("mid_reset_B", B, 32'h0);
    model_reset();
    rst_n = 1'b1;
    drain(st);
    send_frame(32'h0000_00FF, 32'h0000_0001, 3'b100, 4'h0, 1'b0, 8, -1);
    drain(st);
    check("after_reset_valid", st, ST_VALID);

    // Randomized commands checked against the model.
    for (int f = 0; f < 120; f++) begin
      rb   = $urandom;
      ra   = $urandom;
      rop  = 3'($urandom_range(0, 7));
      rsel = int'($urandom_range(0, 9));
      rn   = (rsel == 0) ? 7 : (rsel == 1) ? 9 : 8;
      rx   = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      r7   = ($urandom_range(0, 15) == 0);
      rbad = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, rn)) : -1;
      send_frame(rb, ra, rop, rx, r7, rn, rbad);
      repeat ($urandom_range(0, 2)) send_bit(1'b1);
      if (f % 4 == 3) drain(st);
    end
    drain(st);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
